// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares a single-port instruction memory between the
// read-only fetch port and the read/write debug/loader port. Fetch has
// priority; a starvation counter forces a debug grant after STARVE_MAX
// consecutive denied debug cycles. Read responses are routed back to the
// issuing port one cycle after the grant.
// Optional feature: define IMEM_ARB_ALIGN_CHK_EN to reject misaligned
// accesses (accepted but not issued; error reported next cycle).
module imem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  output logic          f_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DEBUG = 2'd2
  } owner_e;

  owner_e     owner_q;
  owner_e     owner_d;
  logic [3:0] starve_cnt;
  logic       f_err_q;
  logic       d_err_q;
  logic       mis;
  logic       issue;

  // Grant decision: fetch wins ties unless debug has been starved too long
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (f_req && d_req) begin
        if (starve_cnt == STARVE_LIM) d_gnt = 1'b1;
        else                          f_gnt = 1'b1;
      end else begin
        f_gnt = f_req;
        d_gnt = d_req;
      end
    end
  end

`ifdef IMEM_ARB_ALIGN_CHK_EN
  // Misalignment of whichever request is granted this cycle
  always_comb begin
    mis = 1'b0;
    if (f_gnt)      mis = (f_addr[1:0] != 2'b00);
    else if (d_gnt) mis = (d_addr[1:0] != 2'b00);
  end
`else
  assign mis = 1'b0;
`endif

  assign issue = (f_gnt || d_gnt) && !mis;

  // Memory command mux; idle and suppressed cycles drive zeros
  always_comb begin
    mem_en    = issue;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue && f_gnt) begin
      mem_addr = f_addr;
    end else if (issue && d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Next owner: misaligned reads still claim a response slot for the error
  always_comb begin
    owner_d = OWN_NONE;
    if (f_gnt)              owner_d = OWN_FETCH;
    else if (d_gnt && !d_we) owner_d = OWN_DEBUG;
  end

  // Response owner, error flags and starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      f_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      owner_q <= owner_d;
      f_err_q <= f_gnt && mis;
      d_err_q <= d_gnt && mis;
      if (d_req && !d_gnt)
        starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
      else
        starve_cnt <= '0;
    end
  end

  // Responses are masked while in reset so an outstanding read is dropped
  always_comb begin
    f_rvalid = !rst && (owner_q == OWN_FETCH);
    d_rvalid = !rst && (owner_q == OWN_DEBUG);
    f_err    = !rst && f_err_q;
    d_err    = !rst && d_err_q;
    f_rdata  = (f_rvalid && !f_err_q) ? mem_rdata : '0;
    d_rdata  = (d_rvalid && !d_err_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a response scoreboard and a
// simple write-first memory model.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, f_gnt, f_rvalid, f_err;
  logic [31:0] f_addr, f_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        fv;
    logic [31:0] fd;
    logic        fe;
    logic        dv;
    logic [31:0] dd;
    logic        de;
  } resp_t;

  resp_t exp_q[$];

  logic [31:0] mem_model [0:15] = '{32'h00800113, 32'h00400093, 32'h002081b3, 32'h11223344,
                                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                    32'h0, 32'h0, 32'h0, 32'h0};

  imem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Write-first single-port memory, one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr[5:2]] = mem_wdata;
      mem_rdata <= mem_model[mem_addr[5:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic resp_t mk(input logic fv, input logic [31:0] fd, input logic fe,
                               input logic dv, input logic [31:0] dd, input logic de);
    resp_t r;
    r.fv = fv; r.fd = fd; r.fe = fe; r.dv = dv; r.dd = dd; r.de = de;
    return r;
  endfunction

  localparam resp_t NO_RESP = '0;

  // One clock cycle: drive inputs, check grants/command and this cycle's
  // response, then queue the response expected on the next cycle.
  task automatic step(input logic r, input logic fr, input logic [31:0] fa,
                      input logic dr, input logic dwe, input logic [31:0] da,
                      input logic [31:0] dwd, input logic efg, input logic edg,
                      input resp_t enext);
    resp_t e;
    logic  mis;
    logic  eiss;
    @(negedge clk);
    rst = r; f_req = fr; f_addr = fa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    #1;
    chk("f_gnt", 32'(f_gnt), 32'(efg));
    chk("d_gnt", 32'(d_gnt), 32'(edg));
    mis = 1'b0;
`ifdef IMEM_ARB_ALIGN_CHK_EN
    if (efg)      mis = (fa[1:0] != 2'b00);
    else if (edg) mis = (da[1:0] != 2'b00);
`endif
    eiss = (efg || edg) && !mis;
    chk("mem_en", 32'(mem_en), 32'(eiss));
    if (eiss || !(efg || edg)) begin
      chk("mem_we", 32'(mem_we), (eiss && edg) ? 32'(dwe) : 32'd0);
      chk("mem_addr", mem_addr, !eiss ? 32'd0 : (efg ? fa : da));
      chk("mem_wdata", mem_wdata, (eiss && edg) ? dwd : 32'd0);
    end
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("f_rvalid", 32'(f_rvalid), 32'(e.fv));
      chk("f_rdata",  f_rdata,       e.fd);
      chk("f_err",    32'(f_err),    32'(e.fe));
      chk("d_rvalid", 32'(d_rvalid), 32'(e.dv));
      chk("d_rdata",  d_rdata,       e.dd);
      chk("d_err",    32'(d_err),    32'(e.de));
    end
    exp_q.push_back(enext);
  endtask

  initial begin
    rst = 1'b1; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0;
    exp_q.push_back(NO_RESP);

    // Reset held with both requesting
    for (int i = 0; i < 3; i++)
      step(1, 1, 32'd0, 1, 0, 32'd12, 32'd0, 0, 0, NO_RESP);

    // Release: fetch wins the tie; then fetch-only stream
    step(0, 1, 32'd0, 1, 0, 32'd12, 32'd0, 1, 0, mk(1, 32'h00800113, 0, 0, 0, 0));
    step(0, 1, 32'd4, 0, 0, 32'd0,  32'd0, 1, 0, mk(1, 32'h00400093, 0, 0, 0, 0));
    step(0, 1, 32'd8, 0, 0, 32'd0,  32'd0, 1, 0, mk(1, 32'h002081b3, 0, 0, 0, 0));
    step(0, 0, 32'd0, 0, 0, 32'd0,  32'd0, 0, 0, NO_RESP);

    // Starvation: two full rounds show the counter restarts from 0
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < 4; i++)
        step(0, 1, 32'd0, 1, 0, 32'd12, 32'd0, 1, 0, mk(1, 32'h00800113, 0, 0, 0, 0));
      step(0, 1, 32'd0, 1, 0, 32'd12, 32'd0, 0, 1, mk(0, 0, 0, 1, 32'h11223344, 0));
    end
    step(0, 1, 32'd0, 0, 0, 32'd0, 32'd0, 1, 0, mk(1, 32'h00800113, 0, 0, 0, 0));

    // Debug write then read-back of the same word
    step(0, 0, 32'd0, 1, 1, 32'd16, 32'hDEADBEEF, 0, 1, NO_RESP);
    step(0, 0, 32'd0, 1, 0, 32'd16, 32'd0,        0, 1, mk(0, 0, 0, 1, 32'hDEADBEEF, 0));
    step(0, 0, 32'd0, 0, 0, 32'd0,  32'd0,        0, 0, NO_RESP);

    // Reset arriving while a fetch read is outstanding drops the response
    step(0, 1, 32'd12, 0, 0, 32'd0, 32'd0, 1, 0, NO_RESP);
    step(1, 0, 32'd0,  0, 0, 32'd0, 32'd0, 0, 0, NO_RESP);
    step(0, 0, 32'd0,  0, 0, 32'd0, 32'd0, 0, 0, NO_RESP);

    // Misaligned fetch and misaligned debug write, then read back word 4
`ifdef IMEM_ARB_ALIGN_CHK_EN
    step(0, 1, 32'd6, 0, 0, 32'd0, 32'd0, 1, 0, mk(1, 32'h0, 1, 0, 0, 0));
    step(0, 0, 32'd0, 1, 1, 32'd18, 32'hCAFEF00D, 0, 1, mk(0, 0, 0, 0, 0, 1));
    step(0, 0, 32'd0, 1, 0, 32'd16, 32'd0, 0, 1, mk(0, 0, 0, 1, 32'hDEADBEEF, 0));
`else
    step(0, 1, 32'd6, 0, 0, 32'd0, 32'd0, 1, 0, mk(1, 32'h00400093, 0, 0, 0, 0));
    step(0, 0, 32'd0, 1, 1, 32'd18, 32'hCAFEF00D, 0, 1, NO_RESP);
    step(0, 0, 32'd0, 1, 0, 32'd16, 32'd0, 0, 1, mk(0, 0, 0, 1, 32'hCAFEF00D, 0));
`endif
    step(0, 0, 32'd0, 0, 0, 32'd0, 32'd0, 0, 0, NO_RESP);
    step(0, 0, 32'd0, 0, 0, 32'd0, 32'd0, 0, 0, NO_RESP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Arbiter and sequencer for the single-port instruction memory. It shares the memory between two requesters: the core fetch port, which is read-only, and the debug/loader port, which can read and write. It issues at most one memory command per cycle and routes each read response back to the requester that issued it. Fetch has priority, and a starvation counter guarantees that debug eventually gets access. The block sits between the fetch stage and the instruction memory, and between the debug loader and the instruction memory.

## Interface
- AW, 32, address width (byte address, passed through to memory unchanged)
- DW, 32, data width
- STARVE_MAX, 4, number of consecutive denied debug cycles that forces a debug grant (range 1..15)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch read request
- f_addr  in  AW  fetch byte address
- f_gnt  out  1  fetch request accepted this cycle (combinational)
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  DW  fetch read data
- f_err  out  1  fetch misaligned-access error (valid with f_rvalid)
- d_req  in  1  debug request
- d_we  in  1  debug write (1) or read (0)
- d_addr  in  AW  debug byte address
- d_wdata  in  DW  debug write data
- d_gnt  out  1  debug request accepted this cycle (combinational)
- d_rvalid  out  1  debug read data valid
- d_rdata  out  DW  debug read data
- d_err  out  1  debug misaligned-access error (valid with d_rvalid)
- mem_en  out  1  memory command strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory byte address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid the cycle after a read command (mem_en=1 with mem_we=0)

## Operation
**Grant decision (combinational)**
- While rst=1: f_gnt=0, d_gnt=0, mem_en=0.
- If only one requester is active, that requester is granted.
- If both are active, fetch wins unless starve_cnt==STARVE_MAX, in which case debug wins.
- Exactly one grant per cycle at most. A requester must hold req and address stable until it sees its gnt.

**Memory command**
- On a granted cycle: mem_en=1; mem_addr, mem_we and mem_wdata come from the granted port.
- A fetch command always has mem_we=0.
- When nothing is granted, mem_we=0 and mem_addr/mem_wdata are 0.

**Response tracking**
- A 2-bit owner register records {NONE, FETCH, DEBUG}. It is loaded on every edge with the owner of the current read command, or NONE if there was no read command (writes and idle cycles).
- f_rvalid = (owner==FETCH); d_rvalid = (owner==DEBUG).
- {f,d}_rdata = mem_rdata when that port's rvalid is high, otherwise 0.
- Debug writes return no response.

**Starvation counter**
- starve_cnt is 4 bits.
- It increments (saturating at STARVE_MAX) on cycles where d_req=1 and d_gnt=0.
- It clears to 0 on any cycle where d_gnt=1 or d_req=0.

## Timing
- Grant latency: 0 cycles (combinational from req).
- Read latency: rvalid/rdata assert exactly 1 cycle after gnt. Back-to-back reads give one response per cycle.
- Reset values: owner=NONE, starve_cnt=0. All outputs are 0 (rvalid, rdata, err, gnt, mem_*).
- Reset asserted with a read outstanding: the response is dropped, so rvalid=0 on the following cycle.
- With fetch continuously requesting and debug also requesting, debug is granted on cycle STARVE_MAX+1 of its request. The counter then clears.
- A debug write followed by a read of the same address on the next granted cycle returns the new data. This relies on the memory's write-first behaviour; the arbiter adds no forwarding.

## Configuration
- IMEM_ARB_ALIGN_CHK_EN defined:
  - A granted request with addr[1:0]!=0 is accepted (gnt=1) but not issued to memory: mem_en=0 that cycle.
  - For a misaligned read, one cycle later: rvalid=1, rdata=0, err=1.
  - For a misaligned write: the write is dropped and d_err pulses 1 on the next cycle.
  - A misaligned request still clears or increments starve_cnt exactly like a normal request.
- Not defined: no alignment check; addresses pass through unchanged; f_err=d_err=0 always.

## Test plan
- Reset: hold rst=1 for 3 cycles with f_req=d_req=1 -> all outputs 0. Release; next cycle f_gnt=1, d_gnt=0.
- Fetch only: f_addr=0,4,8 on consecutive cycles, memory model returns 00800113/00400093/002081b3 -> f_rvalid high for 3 cycles starting 1 cycle after the first grant, with data in order; d_rvalid=0 throughout.
- Starvation with STARVE_MAX=4: f_req and d_req both held high -> f_gnt for 4 cycles, d_gnt on the 5th, then f_gnt resumes; starve_cnt returns to 0.
- Debug write then read: d_we=1, addr=16, wdata=DEADBEEF; then d_we=0, addr=16 -> no rvalid after the write; d_rvalid=1 with d_rdata=DEADBEEF 1 cycle after the read grant.
- Reset mid-read: fetch granted at addr 12, rst=1 on the next cycle -> f_rvalid stays 0 and owner=NONE.
- With IMEM_ARB_ALIGN_CHK_EN defined: fetch addr=6 -> f_gnt=1 and mem_en=0; next cycle f_rvalid=1, f_err=1, f_rdata=0. Without the macro: mem_en=1, mem_addr=6, f_err=0.
